// File: rtl/main_mem_port.sv
// ============================================================================
// Module   : main_mem_port
// Brief    : Main-memory model for a cache controller: single-word writes and
//            full-line burst reads after a fixed access latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_mem_port #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          MStrobe,
    input  logic                          MRW,
    input  logic [ADDR_W-1:0]             MAddr,
    input  logic [DATA_W-1:0]             MDataIn,
    output logic [DATA_W-1:0]             MDataOut,
    output logic                          MDataValid,
    output logic [$clog2(LINE_WORDS)-1:0] MWordIdx,
    output logic                          CtrSig,
    output logic                          Busy
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT      = 3'd1,
        S_XFER_RD   = 3'd2,
        S_WR_COMMIT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_latch;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_xfer;

    // Line index replaces the low address bits, so a line never crosses its base.
    assign w_rd_addr = {r_addr[ADDR_W-1:IDX_W], r_idx};
    assign w_xfer    = (r_state == S_XFER_RD);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MStrobe) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = C_CNT_LOAD;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = r_rw ? S_WR_COMMIT : S_XFER_RD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_XFER_RD: begin
                if (r_idx == C_IDX_LAST) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            S_WR_COMMIT: w_state_nxt = S_DONE;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            if (w_latch) begin
                r_rw   <= MRW;
                r_addr <= MAddr;
                r_data <= MDataIn;
            end
        end
    end

    // Array has no reset; a write only lands from WR_COMMIT, which reset leaves.
    always_ff @(posedge clk) begin
        if (r_state == S_WR_COMMIT) begin
            r_mem[r_addr] <= r_data;
        end
    end

    assign MDataValid = w_xfer;
    assign MWordIdx   = w_xfer ? r_idx : '0;
    assign MDataOut   = w_xfer ? r_mem[w_rd_addr] : '0;
    assign CtrSig     = (r_state == S_DONE);
    assign Busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_main_mem_port.sv
// ============================================================================
// Module   : tb_main_mem_port
// Brief    : Directed self-checking bench for main_mem_port (LATENCY 4 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_mem_port;

    logic        clk;
    logic        reset;
    logic        MStrobe, MRW;
    logic [7:0]  MAddr;
    logic [31:0] MDataIn, MDataOut;
    logic        MDataValid, CtrSig, Busy;
    logic [1:0]  MWordIdx;

    logic        s1_strobe, s1_rw;
    logic [7:0]  s1_addr;
    logic [31:0] s1_din, s1_dout;
    logic        s1_valid, s1_ctr, s1_busy;
    logic [1:0]  s1_idx;

    int n_checks = 0;
    int n_fail   = 0;

    main_mem_port dut (
        .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
        .MDataIn(MDataIn), .MDataOut(MDataOut), .MDataValid(MDataValid),
        .MWordIdx(MWordIdx), .CtrSig(CtrSig), .Busy(Busy)
    );

    main_mem_port #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .MStrobe(s1_strobe), .MRW(s1_rw), .MAddr(s1_addr),
        .MDataIn(s1_din), .MDataOut(s1_dout), .MDataValid(s1_valid),
        .MWordIdx(s1_idx), .CtrSig(s1_ctr), .Busy(s1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (Busy && k < 40) begin
            step();
            k++;
        end
        check_val(tag, 32'(Busy), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        MStrobe = 1'b1; MRW = 1'b1; MAddr = a; MDataIn = d;
        step();
        MStrobe = 1'b0; MAddr = ~a; MDataIn = ~d;
        wait_idle("wr_done");
    endtask

    // Strobe at E0, then k counts edges E1..E9; hold keeps MStrobe high throughout.
    task automatic read_line(input logic [7:0] a, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3, input bit hold);
        logic [31:0] ew [4];
        int n_ctr;
        ew[0] = e0; ew[1] = e1; ew[2] = e2; ew[3] = e3;
        n_ctr = 0;
        MStrobe = 1'b1; MRW = 1'b0; MAddr = a; MDataIn = 32'h0;
        step();
        MAddr = a ^ 8'h80; MDataIn = 32'hBAD0_BAD0;
        if (!hold) begin
            MStrobe = 1'b0; MRW = 1'b1;
        end
        check_val("rd_busy_e0", 32'(Busy), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            step();
            if (CtrSig) n_ctr++;
            if (k < 4) begin
                check_val("rd_valid_wait", 32'(MDataValid), 32'd0);
            end else if (k <= 7) begin
                check_val("rd_valid", 32'(MDataValid), 32'd1);
                check_val("rd_idx", 32'(MWordIdx), 32'(k - 4));
                check_val("rd_data", MDataOut, ew[k-4]);
            end else if (k == 8) begin
                check_val("rd_ctr", 32'(CtrSig), 32'd1);
                check_val("rd_valid_done", 32'(MDataValid), 32'd0);
                check_val("rd_data_done", MDataOut, 32'd0);
            end else begin
                check_val("rd_busy_end", 32'(Busy), 32'd0);
            end
        end
        check_val("rd_ctr_count", 32'(n_ctr), 32'd1);
        if (hold) begin
            step();
            check_val("rd_reaccept", 32'(Busy), 32'd1);
            MStrobe = 1'b0; MRW = 1'b0;
            wait_idle("rd_reaccept_done");
        end
    endtask

    task automatic wr1(input logic [7:0] a, input logic [31:0] d);
        s1_strobe = 1'b1; s1_rw = 1'b1; s1_addr = a; s1_din = d;
        step();
        s1_strobe = 1'b0; s1_addr = 8'h00; s1_din = 32'h0;
        step();
        check_val("l1_wr_ctr_e1", 32'(s1_ctr), 32'd0);
        step();
        check_val("l1_wr_ctr_e2", 32'(s1_ctr), 32'd1);
        step();
        check_val("l1_wr_busy_e3", 32'(s1_busy), 32'd0);
    endtask

    initial begin
        int n_ctr;
        reset = 1'b1;
        MStrobe = 1'b0; MRW = 1'b0; MAddr = 8'h0; MDataIn = 32'h0;
        s1_strobe = 1'b0; s1_rw = 1'b0; s1_addr = 8'h0; s1_din = 32'h0;
        #2;
        check_val("rst_busy", 32'(Busy), 32'd0);
        check_val("rst_ctr", 32'(CtrSig), 32'd0);
        check_val("rst_valid", 32'(MDataValid), 32'd0);
        check_val("rst_data", MDataOut, 32'd0);
        check_val("rst_idx", 32'(MWordIdx), 32'd0);
        step();
        step();
        reset = 1'b0;

        // Write timing: CtrSig only after E5, Busy low after E6
        MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h13; MDataIn = 32'hA5A5_0001;
        step();
        MStrobe = 1'b0; MAddr = 8'h00; MDataIn = 32'h0;
        check_val("wr_busy_e0", 32'(Busy), 32'd1);
        n_ctr = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k <= 4 && CtrSig) n_ctr++;
            if (k == 4) check_val("wr_ctr_early", 32'(n_ctr), 32'd0);
            if (k == 5) begin
                check_val("wr_ctr_e5", 32'(CtrSig), 32'd1);
                check_val("wr_busy_e5", 32'(Busy), 32'd1);
            end
            if (k == 6) begin
                check_val("wr_busy_e6", 32'(Busy), 32'd0);
                check_val("wr_ctr_e6", 32'(CtrSig), 32'd0);
            end
        end

        for (int i = 0; i < 4; i++) do_write(8'h10 + 8'(i), 32'h100 + 32'(i));
        read_line(8'h12, 32'h100, 32'h101, 32'h102, 32'h103, 1'b0);

        // Top-of-memory line, MStrobe held and MAddr changed mid-request
        for (int i = 0; i < 4; i++) do_write(8'hFC + 8'(i), 32'hF000_00FC + 32'(i));
        do_write(8'h00, 32'hDEAD_BEEF);
        read_line(8'hFF, 32'hF000_00FC, 32'hF000_00FD, 32'hF000_00FE, 32'hF000_00FF, 1'b1);

        // Abort a write in WAIT; old contents must survive
        do_write(8'h20, 32'h55);
        for (int i = 1; i < 4; i++) do_write(8'h20 + 8'(i), 32'h20 + 32'(i));
        MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h20; MDataIn = 32'h77;
        step();
        MStrobe = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        check_val("abort_busy", 32'(Busy), 32'd0);
        check_val("abort_ctr", 32'(CtrSig), 32'd0);
        check_val("abort_valid", 32'(MDataValid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n_ctr = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (CtrSig) n_ctr++;
        end
        check_val("abort_no_ctr", 32'(n_ctr), 32'd0);
        read_line(8'h20, 32'h55, 32'h21, 32'h22, 32'h23, 1'b0);

        // LATENCY=1 instance
        wr1(8'h04, 32'hAAAA_0004);
        wr1(8'h05, 32'h0000_1234);
        s1_strobe = 1'b1; s1_rw = 1'b0; s1_addr = 8'h05;
        step();
        s1_strobe = 1'b0; s1_addr = 8'h00;
        check_val("l1_valid_e0", 32'(s1_valid), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k <= 4) begin
                check_val("l1_valid", 32'(s1_valid), 32'd1);
                check_val("l1_idx", 32'(s1_idx), 32'(k - 1));
            end
            if (k == 1) check_val("l1_data0", s1_dout, 32'hAAAA_0004);
            if (k == 2) check_val("l1_data1", s1_dout, 32'h0000_1234);
            if (k == 4) check_val("l1_ctr_e4", 32'(s1_ctr), 32'd0);
            if (k == 5) check_val("l1_ctr_e5", 32'(s1_ctr), 32'd1);
            if (k == 6) check_val("l1_busy_e6", 32'(s1_busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
